// File: rtl/pcie_crdt_up_sched.sv
// Upstream credit scheduler: six credit pools, RQ/CC round-robin arbiter, one-cycle GNT pulse one edge after REQ.
// Backpressure: a requester with insufficient credits waits with REQ held; it never blocks the other requester.
module pcie_crdt_up_sched #(
    parameter int HDR_UPD_W  = 2,
    parameter int DATA_UPD_W = 4,
    parameter int CNT_W      = 16,
    parameter int DCRDT_W    = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  crdt_up_init_done_i,
    input  logic [5:0]            crdt_up_update_i,
    input  logic [HDR_UPD_W-1:0]  crdt_up_cnt_ph_i,
    input  logic [HDR_UPD_W-1:0]  crdt_up_cnt_nph_i,
    input  logic [HDR_UPD_W-1:0]  crdt_up_cnt_cplh_i,
    input  logic [DATA_UPD_W-1:0] crdt_up_cnt_pd_i,
    input  logic [DATA_UPD_W-1:0] crdt_up_cnt_npd_i,
    input  logic [DATA_UPD_W-1:0] crdt_up_cnt_cpld_i,
    input  logic                  rq_req_i,
    input  logic                  rq_np_i,
    input  logic [DCRDT_W-1:0]    rq_dcrdt_i,
    output logic                  rq_gnt_o,
    input  logic                  cc_req_i,
    input  logic [DCRDT_W-1:0]    cc_dcrdt_i,
    output logic                  cc_gnt_o,
    output logic [5:0]            infinite_o,
    output logic                  ovf_err_o
);

    localparam int PH   = 5;
    localparam int NPH  = 4;
    localparam int CPLH = 3;
    localparam int PD   = 2;
    localparam int NPD  = 1;
    localparam int CPLD = 0;

    // One spare bit so pool + update and demand comparisons never wrap.
    localparam int EW = ((CNT_W > DCRDT_W) ? CNT_W : DCRDT_W) + 1;
    localparam logic [EW-1:0] MAX_E = {{(EW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] pool_q [6];
    logic [CNT_W-1:0] pool_d [6];
    logic [5:0]       inf_q;
    logic             ovf_q;
    logic             rq_gnt_q;
    logic             cc_gnt_q;
    logic             ptr_q;   // 1: CC has priority on a tie

    logic [EW-1:0]    upd_e  [6];
    logic [EW-1:0]    cons_e [6];
    logic [EW-1:0]    sum_e  [6];
    logic             ovf_set;
    logic             rq_hdr_ok, rq_dat_ok, cc_hdr_ok, cc_dat_ok;
    logic             rq_ok, cc_ok, rq_win, cc_win;

    assign upd_e[PH]   = crdt_up_update_i[PH]   ? EW'(crdt_up_cnt_ph_i)   : '0;
    assign upd_e[NPH]  = crdt_up_update_i[NPH]  ? EW'(crdt_up_cnt_nph_i)  : '0;
    assign upd_e[CPLH] = crdt_up_update_i[CPLH] ? EW'(crdt_up_cnt_cplh_i) : '0;
    assign upd_e[PD]   = crdt_up_update_i[PD]   ? EW'(crdt_up_cnt_pd_i)   : '0;
    assign upd_e[NPD]  = crdt_up_update_i[NPD]  ? EW'(crdt_up_cnt_npd_i)  : '0;
    assign upd_e[CPLD] = crdt_up_update_i[CPLD] ? EW'(crdt_up_cnt_cpld_i) : '0;

    always_comb begin
        rq_hdr_ok = rq_np_i ? (inf_q[NPH] || pool_q[NPH] != '0)
                            : (inf_q[PH]  || pool_q[PH]  != '0);
        rq_dat_ok = rq_np_i ? (inf_q[NPD] || EW'(pool_q[NPD]) >= EW'(rq_dcrdt_i))
                            : (inf_q[PD]  || EW'(pool_q[PD])  >= EW'(rq_dcrdt_i));
        cc_hdr_ok = inf_q[CPLH] || pool_q[CPLH] != '0;
        cc_dat_ok = inf_q[CPLD] || EW'(pool_q[CPLD]) >= EW'(cc_dcrdt_i);

        // A requester's REQ is ignored while its own GNT is high.
        rq_ok  = (state_q == ST_RUN) && rq_req_i && !rq_gnt_q && rq_hdr_ok && rq_dat_ok;
        cc_ok  = (state_q == ST_RUN) && cc_req_i && !cc_gnt_q && cc_hdr_ok && cc_dat_ok;
        rq_win = rq_ok && (!cc_ok || !ptr_q);
        cc_win = cc_ok && (!rq_ok || ptr_q);

        for (int i = 0; i < 6; i++) begin
            cons_e[i] = '0;
        end
        if (rq_win) begin
            if (rq_np_i) begin
                cons_e[NPH] = EW'(1);
                cons_e[NPD] = EW'(rq_dcrdt_i);
            end else begin
                cons_e[PH] = EW'(1);
                cons_e[PD] = EW'(rq_dcrdt_i);
            end
        end
        if (cc_win) begin
            cons_e[CPLH] = EW'(1);
            cons_e[CPLD] = EW'(cc_dcrdt_i);
        end

        ovf_set = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (inf_q[i]) begin
                cons_e[i] = '0;
            end
            sum_e[i] = EW'(pool_q[i]) + upd_e[i];
            if (sum_e[i] > MAX_E) begin
                sum_e[i] = MAX_E;
                ovf_set  = 1'b1;
            end
            pool_d[i] = CNT_W'(sum_e[i] - cons_e[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_INIT;
            for (int i = 0; i < 6; i++) begin
                pool_q[i] <= '0;
            end
            inf_q    <= '0;
            ovf_q    <= 1'b0;
            rq_gnt_q <= 1'b0;
            cc_gnt_q <= 1'b0;
            ptr_q    <= 1'b0;
        end else begin
            rq_gnt_q <= 1'b0;
            cc_gnt_q <= 1'b0;
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                ST_INIT: begin
                    for (int i = 0; i < 6; i++) begin
                        pool_q[i] <= pool_d[i];
                    end
                    if (crdt_up_init_done_i) begin
                        state_q <= ST_RUN;
                        for (int i = 0; i < 6; i++) begin
                            inf_q[i] <= (pool_d[i] == '0);
                        end
                    end
                end
                ST_RUN: begin
                    if (!crdt_up_init_done_i) begin
                        // Link re-init: forget all credits, keep the sticky error.
                        state_q <= ST_INIT;
                        inf_q   <= '0;
                        for (int i = 0; i < 6; i++) begin
                            pool_q[i] <= '0;
                        end
                    end else begin
                        for (int i = 0; i < 6; i++) begin
                            pool_q[i] <= pool_d[i];
                        end
                        rq_gnt_q <= rq_win;
                        cc_gnt_q <= cc_win;
                        if (rq_win || cc_win) begin
                            ptr_q <= rq_win;
                        end
                    end
                end
            endcase
        end
    end

    assign rq_gnt_o   = rq_gnt_q;
    assign cc_gnt_o   = cc_gnt_q;
    assign infinite_o = inf_q;
    assign ovf_err_o  = ovf_q;

endmodule
